mod_spi: RTL and testbench
==========================

Name: mod_spi

Overview:
- Memory-mapped SPI master peripheral; occupies one module slot on the CPU bus and uses the standard module port set.
- Decoded by the address-map block to a module-enable plus effective address.
- Mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- One-byte TX holding register, 4-entry RX FIFO, one-cycle completion interrupt pulse for the interrupt controller.

Parameters:
- RX_DEPTH, 4, RX FIFO entries (power of two).
- DIV_RESET, 8'h0F, reset value of the clock divider register.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- ie  in  1  instruction-side module enable.
- de  in  1  data-side module enable.
- iaddr  in  32  instruction effective address (unused).
- daddr  in  32  data effective address; only bits [3:2] are decoded.
- drw  in  2  00 nop, 01 write, 10 read.
- bin  in  32  write data from CPU.
- iout  out  32  instruction data; constant 0.
- dout  out  32  read data; combinational from daddr.
- cpu_stall  in  1  bus stall; qualifies all side effects.
- spi_sclk  out  1  serial clock.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.
- spi_cs_n  out  1  chip select, software controlled.
- i_spi  out  1  one-cycle pulse per completed byte.

Behaviour:
- Strobes:
  - wr = de & drw==01 & ~cpu_stall.
  - rd = de & drw==10 & ~cpu_stall.
  - Side effects occur only on strobe edges.
- Register map, by daddr[3:2]:
  - 0 STATUS/CTRL. Read: {27'b0, ovf, rx_full, rx_empty, tx_full, busy}. Write: bit0 sets cs (spi_cs_n = ~cs); bit4=1 clears ovf.
  - 1 TX. Write: loads bin[7:0] into the holding register and sets tx_full, only if tx_full=0 at that edge; otherwise the write is ignored. Reads return 0.
  - 2 RX. dout = {24'b0, FIFO head}, or 0 if empty. rd pops the head if non-empty; rd on an empty FIFO has no effect.
  - 3 DIV. R/W bits[7:0]. Each SCLK half-period lasts div+1 clk cycles.
- Reset values: spi_sclk=0, spi_mosi=0, spi_cs_n=1, i_spi=0, FIFO empty, ovf=0, tx_full=0, div=DIV_RESET, FSM=IDLE. A reset mid-transfer aborts the byte; no push, no pulse.
- FSM:
  - IDLE: sclk=0. If tx_full, copy the holding register to the shifter, clear tx_full, set mosi=bit7, cnt=div, bit=0, go to LOW.
  - LOW: sclk=0. When cnt==0: go to HIGH, raise sclk, sample miso into shifter LSB, cnt=div. Otherwise decrement cnt.
  - HIGH: sclk=1. When cnt==0: lower sclk. If bit==7, go to DONE. Otherwise shift, drive the next MSB on mosi, bit++, cnt=div, go to LOW. Otherwise decrement cnt.
  - DONE: i_spi=1 for this cycle only. Push the received byte; if the FIFO is full, drop it and set ovf. Go to IDLE.
- busy = (state != IDLE).
- Timing: i_spi is high in the cycle beginning 16*(div+1)+1 edges after the edge that accepted the TX write, given the FSM was idle. The received byte is readable the following cycle.
- A TX write during a transfer refills the holding register. The next byte starts on the IDLE cycle after DONE (two-cycle inter-byte gap).
- A DIV write during a transfer takes effect at the next cnt reload.
- Simultaneous pop and push on a full FIFO: both occur, ovf unchanged, FIFO stays full.
- A TX write on the same edge IDLE consumes the holding register is ignored, because tx_full was 1 at that edge.
- cs has no effect on the FSM; software brackets transfers.
- ie/iaddr are ignored; iout=0.

Test Plan:
- Reset: rst=0 for 2 cycles -> sclk=0, cs_n=1, STATUS reads 0x04, DIV reads 0x0F.
- Loopback (miso=mosi), div=0, write TX=0xA5 -> mosi bits 1,0,1,0,0,1,0,1 on rising edges; i_spi pulse 17 cycles after the write; RX reads 0xA5, then STATUS.rx_empty=1.
- Write 5 bytes 0x01..0x05 without reading, div=1 -> 4th push sets rx_full, 5th sets ovf=1; reads return 0x01..0x04; write STATUS bit4 -> ovf=0.
- Hold cpu_stall=1 for 3 cycles with drw=10 at RX -> exactly one pop after stall drops; same check for a TX write -> one byte sent.
- Assert rst=0 mid-byte (bit 3 of 0xFF) -> no i_spi, FIFO empty, sclk=0 next cycle; a new write 0x3C after reset transfers correctly.
- Write DIV=3 during a transfer at div=0 -> remaining half-periods are 4 cycles; completion pulse time matches the mixed count.

Source files
------------

// File: rtl/mod_spi.sv
// mod_spi: memory-mapped SPI master, mode 0, MSB first, 8-bit frames.
// TX holding register, small RX FIFO, one-cycle completion pulse.
`timescale 1ns/1ps
module mod_spi #(
  parameter int unsigned RX_DEPTH  = 4,
  parameter logic [7:0]  DIV_RESET = 8'h0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ie,
  input  logic        de,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [1:0]  drw,
  input  logic [31:0] bin,
  output logic [31:0] iout,
  output logic [31:0] dout,
  input  logic        cpu_stall,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        i_spi
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] FULL_CNT = RX_DEPTH[AW:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic wr;
  logic rd;
  logic sel_st;
  logic sel_tx;
  logic sel_rx;
  logic sel_dv;

  logic       cs_q;
  logic       ovf_q;
  logic       tx_full_q;
  logic [7:0] hold_q;
  logic [7:0] div_q;
  logic [7:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic       mosi_q;

  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          rx_empty;
  logic          rx_full;
  logic [7:0]    head;

  logic load;
  logic rise;
  logic fall;
  logic dec;
  logic push;
  logic pop;
  logic push_ok;
  logic busy;

  logic unused;
  assign unused = ^{ie, iaddr, daddr[31:4],
                    daddr[1:0], bin[31:8]};

  assign wr = de & (drw == 2'b01) & ~cpu_stall;
  assign rd = de & (drw == 2'b10) & ~cpu_stall;

  assign sel_st = daddr[3:2] == 2'd0;
  assign sel_tx = daddr[3:2] == 2'd1;
  assign sel_rx = daddr[3:2] == 2'd2;
  assign sel_dv = daddr[3:2] == 2'd3;

  assign rx_empty = count == '0;
  assign rx_full  = count == FULL_CNT;
  assign head     = mem[rd_ptr];

  assign push    = state_q == S_DONE;
  assign pop     = rd & sel_rx & ~rx_empty;
  // A pop on the same edge frees the slot a full FIFO needs.
  assign push_ok = push & (~rx_full | pop);

  assign busy     = state_q != S_IDLE;
  assign i_spi    = state_q == S_DONE;
  assign spi_sclk = state_q == S_HIGH;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = ~cs_q;
  assign iout     = '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_full_q) begin
          load    = 1'b1;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt_q == 8'd0) begin
          rise    = 1'b1;
          state_d = S_HIGH;
        end else begin
          dec = 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == 8'd0) begin
          if (bit_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            fall    = 1'b1;
            state_d = S_LOW;
          end
        end else begin
          dec = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Shifter samples miso on the rising edge and presents
  // the next MSB on mosi at the falling edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= 8'd0;
      bit_q  <= 3'd0;
      sh_q   <= 8'd0;
      mosi_q <= 1'b0;
    end else begin
      if (load | rise | fall) begin
        cnt_q <= div_q;
      end else if (dec) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (load) begin
        sh_q   <= hold_q;
        mosi_q <= hold_q[7];
        bit_q  <= 3'd0;
      end else begin
        if (rise) begin
          sh_q <= {sh_q[6:0], spi_miso};
        end
        if (fall) begin
          mosi_q <= sh_q[7];
          bit_q  <= bit_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_q      <= 1'b0;
      ovf_q     <= 1'b0;
      tx_full_q <= 1'b0;
      hold_q    <= 8'd0;
      div_q     <= DIV_RESET;
    end else begin
      if (wr & sel_st) begin
        cs_q <= bin[0];
      end
      if (wr & sel_st & bin[4]) begin
        ovf_q <= 1'b0;
      end
      if (push & rx_full & ~pop) begin
        ovf_q <= 1'b1;
      end
      if (wr & sel_tx & ~tx_full_q) begin
        hold_q    <= bin[7:0];
        tx_full_q <= 1'b1;
      end else if (load) begin
        tx_full_q <= 1'b0;
      end
      if (wr & sel_dv) begin
        div_q <= bin[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok & ~pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop & ~push_ok) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= sh_q;
    end
  end

  always_comb begin
    dout = '0;
    unique case (1'b1)
      sel_st: dout = {27'b0, ovf_q, rx_full,
                      rx_empty, tx_full_q, busy};
      sel_tx: dout = '0;
      sel_rx: dout = rx_empty ? '0 : {24'b0, head};
      sel_dv: dout = {24'b0, div_q};
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_mod_spi.sv
// tb_mod_spi: register table, directed SPI sequences and
// randomized loopback transfers against a queue-based model.
`timescale 1ns/1ps
module tb_mod_spi;

  localparam logic [1:0] A_ST = 2'd0;
  localparam logic [1:0] A_TX = 2'd1;
  localparam logic [1:0] A_RX = 2'd2;
  localparam logic [1:0] A_DV = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ie = 1'b1;
  logic        de = 1'b0;
  logic [31:0] iaddr = 32'hDEAD_BEEF;
  logic [31:0] daddr = '0;
  logic [1:0]  drw = 2'b00;
  logic [31:0] bin = '0;
  logic [31:0] iout;
  logic [31:0] dout;
  logic        cpu_stall = 1'b0;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_cs_n;
  logic        i_spi;
  logic        inv = 1'b0;

  assign spi_miso = spi_mosi ^ inv;

  mod_spi dut (
    .clk(clk), .rst(rst), .ie(ie), .de(de),
    .iaddr(iaddr), .daddr(daddr), .drw(drw),
    .bin(bin), .iout(iout), .dout(dout),
    .cpu_stall(cpu_stall), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .i_spi(i_spi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   pulse_q[$];
  bit   bitq[$];
  logic sclk_prev = 1'b0;
  always @(negedge clk) begin
    if (i_spi) pulse_q.push_back(cyc);
    if (spi_sclk && !sclk_prev) bitq.push_back(spi_mosi);
    sclk_prev = spi_sclk;
  end

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [1:0] a,
                        input logic [31:0] d,
                        output int en);
    de = 1'b1; drw = 2'b01;
    daddr = {28'h0, a, 2'b00}; bin = d;
    @(posedge clk); #1;
    en = cyc;
    de = 1'b0; drw = 2'b00;
  endtask

  task automatic rd_reg(input logic [1:0] a,
                        output logic [31:0] d);
    de = 1'b1; drw = 2'b10;
    daddr = {28'h0, a, 2'b00};
    #1 d = dout;
    @(posedge clk); #1;
    de = 1'b0; drw = 2'b00;
  endtask

  task automatic wait_pulse(input int budget, output int pe);
    int t = 0;
    while (pulse_q.size() == 0 && t < budget) begin
      @(posedge clk); #1; t++;
    end
    if (pulse_q.size() == 0) begin
      nchk++; nerr++;
      $display("FAIL pulse_wait: got none required i_spi in %0d cycles",
               budget);
      pe = -1;
    end else begin
      pe = pulse_q.pop_front();
    end
  endtask

  function automatic int delta(input int d);
    return 16 * (d + 1) + 1;
  endfunction

  // Half-period k starts at an edge and lasts div+1 cycles, using the
  // divider value visible before that edge.
  function automatic int done_edge(input int e0, input int w,
                                   input int d_old, input int d_new);
    int s = e0 + 1;
    for (int k = 0; k < 16; k++) begin
      s += ((w < s) ? d_new : d_old) + 1;
    end
    return s;
  endfunction

  typedef struct {
    bit          w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    logic        csn;
    string       nm;
  } vec_t;

  vec_t tbl[11];
  logic [7:0] mq[$];
  bit movf;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  b, eb;
    int e0, pe, w, d;

    tbl[0]  = '{0, A_ST, 0,       32'h04, 1, "rst_status"};
    tbl[1]  = '{0, A_DV, 0,       32'h0F, 1, "rst_div"};
    tbl[2]  = '{0, A_TX, 0,       32'h00, 1, "tx_reads_0"};
    tbl[3]  = '{0, A_RX, 0,       32'h00, 1, "rx_empty_0"};
    tbl[4]  = '{1, A_ST, 32'h1,   32'h00, 0, "cs_on"};
    tbl[5]  = '{0, A_ST, 0,       32'h04, 0, "status_cs"};
    tbl[6]  = '{1, A_DV, 32'h1AB, 32'h00, 0, "div_wr"};
    tbl[7]  = '{0, A_DV, 0,       32'hAB, 0, "div_mask"};
    tbl[8]  = '{1, A_ST, 32'h0,   32'h00, 1, "cs_off"};
    tbl[9]  = '{1, A_DV, 32'h0F,  32'h00, 1, "div_restore"};
    tbl[10] = '{0, A_DV, 0,       32'h0F, 1, "div_back"};

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_sclk", {31'b0, spi_sclk}, 0);
    check("rst_csn", {31'b0, spi_cs_n}, 1);
    check("rst_mosi", {31'b0, spi_mosi}, 0);
    check("rst_irq", {31'b0, i_spi}, 0);
    check("iout_zero", iout, 0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].w) wr_reg(tbl[i].a, tbl[i].d, e0);
      else begin
        rd_reg(tbl[i].a, r);
        check(tbl[i].nm, r, tbl[i].exp);
      end
      check({tbl[i].nm, "_csn"}, {31'b0, spi_cs_n},
            {31'b0, tbl[i].csn});
    end

    // Loopback 0xA5 at div=0
    wr_reg(A_DV, 0, e0);
    bitq.delete(); pulse_q.delete();
    wr_reg(A_TX, 32'hA5, e0);
    wait_pulse(200, pe);
    check("a5_latency", pe - e0, 17);
    check("a5_nbits", bitq.size(), 8);
    b = '0;
    while (bitq.size() > 0) b = {b[6:0], bitq.pop_front()};
    check("a5_mosi", {24'b0, b}, 32'hA5);
    rd_reg(A_RX, r);
    check("a5_rx", r, 32'hA5);
    rd_reg(A_ST, r);
    check("a5_empty", r, 32'h04);

    // Overflow: five bytes, FIFO holds four
    wr_reg(A_DV, 1, e0);
    for (int i = 1; i <= 5; i++) begin
      wr_reg(A_TX, i, e0);
      wait_pulse(200, pe);
      check("ovf_latency", pe - e0, delta(1));
      if (i >= 4) begin
        rd_reg(A_ST, r);
        check("ovf_status", r, (i == 4) ? 32'h08 : 32'h18);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      rd_reg(A_RX, r);
      check("ovf_rx", r, i);
    end
    rd_reg(A_ST, r);
    check("ovf_kept", r, 32'h14);
    wr_reg(A_ST, 32'h10, e0);
    rd_reg(A_ST, r);
    check("ovf_clear", r, 32'h04);

    // Stalled read pops once
    wr_reg(A_TX, 32'h5A, e0); wait_pulse(200, pe);
    wr_reg(A_TX, 32'hC3, e0); wait_pulse(200, pe);
    de = 1'b1; drw = 2'b10; daddr = {28'h0, A_RX, 2'b00};
    cpu_stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 cpu_stall = 1'b0;
    @(posedge clk); #1;
    de = 1'b0; drw = 2'b00;
    rd_reg(A_RX, r);
    check("stall_pop", r, 32'hC3);
    rd_reg(A_ST, r);
    check("stall_empty", r, 32'h04);

    // Stalled write sends once
    pulse_q.delete();
    de = 1'b1; drw = 2'b01; daddr = {28'h0, A_TX, 2'b00};
    bin = 32'h77; cpu_stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 cpu_stall = 1'b0;
    @(posedge clk); #1;
    e0 = cyc;
    de = 1'b0; drw = 2'b00;
    wait_pulse(200, pe);
    check("stall_tx_lat", pe - e0, delta(1));
    repeat (60) @(posedge clk);
    #1 check("stall_tx_once", pulse_q.size(), 0);
    rd_reg(A_RX, r);
    check("stall_tx_rx", r, 32'h77);

    // Reset during bit 3 of 0xFF
    wr_reg(A_DV, 0, e0);
    bitq.delete(); pulse_q.delete();
    wr_reg(A_TX, 32'hFF, e0);
    w = 0;
    while (bitq.size() < 4 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("rst_mid_bits", bitq.size(), 4);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_mid_sclk", {31'b0, spi_sclk}, 0);
    repeat (40) @(posedge clk);
    #1 check("rst_mid_nopulse", pulse_q.size(), 0);
    rd_reg(A_ST, r);
    check("rst_mid_status", r, 32'h04);
    rd_reg(A_DV, r);
    check("rst_mid_div", r, 32'h0F);
    bitq.delete();
    wr_reg(A_TX, 32'h3C, e0);
    wait_pulse(400, pe);
    check("post_rst_lat", pe - e0, delta(15));
    b = '0;
    while (bitq.size() > 0) b = {b[6:0], bitq.pop_front()};
    check("post_rst_mosi", {24'b0, b}, 32'h3C);
    rd_reg(A_RX, r);
    check("post_rst_rx", r, 32'h3C);

    // Divider change mid-transfer
    wr_reg(A_DV, 0, e0);
    wr_reg(A_TX, 32'h96, e0);
    repeat (3) @(posedge clk);
    #1 wr_reg(A_DV, 3, w);
    wait_pulse(300, pe);
    check("div_mix_done", pe, done_edge(e0, w, 0, 3));
    rd_reg(A_RX, r);
    check("div_mix_rx", r, 32'h96);

    // Randomized transfers against a FIFO model
    movf = 0;
    for (int it = 0; it < 24; it++) begin
      d = $urandom_range(0, 2);
      wr_reg(A_DV, d, e0);
      inv = $urandom_range(0, 1);
      b = 8'($urandom_range(0, 255));
      wr_reg(A_TX, {24'b0, b}, e0);
      wait_pulse(200, pe);
      check("rnd_latency", pe - e0, delta(d));
      eb = inv ? ~b : b;
      if (mq.size() == 4) movf = 1;
      else mq.push_back(eb);
      if ($urandom_range(0, 2) != 0) begin
        rd_reg(A_RX, r);
        check("rnd_rx", r,
              (mq.size() > 0) ? {24'b0, mq.pop_front()} : 32'h0);
      end
      rd_reg(A_ST, r);
      check("rnd_status", r,
            {27'b0, movf, mq.size() == 4, mq.size() == 0, 2'b00});
      if (movf && $urandom_range(0, 1) == 1) begin
        wr_reg(A_ST, 32'h10, e0);
        movf = 0;
      end
    end
    inv = 1'b0;
    wr_reg(A_ST, 32'h10, e0);
    while (mq.size() > 0) begin
      rd_reg(A_RX, r);
      check("rnd_drain", r, {24'b0, mq.pop_front()});
    end
    rd_reg(A_ST, r);
    check("rnd_final", r, 32'h04);

    // Pop and push on the same edge with a full FIFO
    wr_reg(A_DV, 0, e0);
    for (int i = 1; i <= 4; i++) begin
      wr_reg(A_TX, 32'h11 * i, e0);
      wait_pulse(200, pe);
    end
    wr_reg(A_TX, 32'h55, e0);
    repeat (17) @(posedge clk);
    #1 check("sim_in_done", {31'b0, i_spi}, 1);
    rd_reg(A_RX, r);
    check("sim_head", r, 32'h11);
    rd_reg(A_ST, r);
    check("sim_status", r, 32'h08);
    for (int i = 2; i <= 5; i++) begin
      rd_reg(A_RX, r);
      check("sim_rx", r, 32'h11 * i);
    end
    rd_reg(A_ST, r);
    check("sim_empty", r, 32'h04);
    pulse_q.delete();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
